axis_xmit_monitor: RTL and testbench

Parametrised successor to the CMAC transmit checker. Passively monitors an AXI-Stream transmit interface and enforces packet framing: one header beat followed by a payload whose length falls in a configurable allowed set. Records sticky error bits, the beat count at fault, and a running packet count. Errors can be cleared at run time without a full reset. Sits in parallel with the CMAC axis_tx path and never drives the bus.

---
 rtl/axis_xmit_monitor.sv | 189 ++++++++++++++++++
 tb/tb_axis_xmit_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_xmit_monitor.sv
// Passive AXI-Stream transmit framing monitor: header beat + payload of allowed length.
// Optional tdata/tlast hold-stability check enabled by defining XMIT_STABLE_CHECK_EN.
module axis_xmit_monitor #(
   parameter int unsigned DW     = 512,
   parameter int unsigned CW     = 16,
   parameter int unsigned PCW    = 32,
   parameter int unsigned SIZE_A = 1,
   parameter int unsigned SIZE_B = 2,
   parameter int unsigned SIZE_C = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [DW-1:0]  axis_in_tdata,
   input  logic           axis_in_tlast,
   input  logic           axis_in_tvalid,
   input  logic           axis_in_tready,
   input  logic           clear,
   output logic [4:0]     error_code,
   output logic [CW-1:0]  cycle_count,
   output logic [PCW-1:0] packet_count,
   output logic           fault
);

   localparam int unsigned EW   = 5;
   localparam int unsigned LW   = CW + 1;
   localparam int unsigned CMPW = (LW > 32) ? LW : 32;
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   localparam int unsigned E_TLAST    = 0;
   localparam int unsigned E_DROPPED  = 1;
   localparam int unsigned E_SIZE     = 2;
   localparam int unsigned E_OVERFLOW = 3;
   localparam int unsigned E_UNSTABLE = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HEADER  = 2'd1,
      S_PAYLOAD = 2'd2,
      S_FAULT   = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [EW-1:0]  error_q, error_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PCW-1:0] pkt_q, pkt_d;

   logic           beat_c;
   logic [LW-1:0]  len_c;
   logic           len_ok_c;
   logic [EW-1:0]  err_new_c;
   logic           stable_err_c;

   assign beat_c = axis_in_tvalid & axis_in_tready;
   assign len_c  = {1'b0, count_q} + LW'(1);

   // Final payload length against the allowed set; a zero slot never matches
   assign len_ok_c = ((SIZE_A != 32'd0) && (CMPW'(len_c) == CMPW'(SIZE_A))) ||
                     ((SIZE_B != 32'd0) && (CMPW'(len_c) == CMPW'(SIZE_B))) ||
                     ((SIZE_C != 32'd0) && (CMPW'(len_c) == CMPW'(SIZE_C)));

`ifdef XMIT_STABLE_CHECK_EN
   logic [DW-1:0] hold_data_q, hold_data_d;
   logic          hold_last_q, hold_last_d;
   logic          hold_vld_q,  hold_vld_d;

   // Capture the stalled transfer so the next cycle can verify it was held
   always_comb begin
      hold_vld_d  = 1'b0;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
      if (!clear && (state_q != S_FAULT) && axis_in_tvalid && !axis_in_tready) begin
         hold_vld_d  = 1'b1;
         hold_data_d = axis_in_tdata;
         hold_last_d = axis_in_tlast;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_vld_q  <= 1'b0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
      end
   end

   assign stable_err_c = hold_vld_q && axis_in_tvalid &&
                         ((axis_in_tdata != hold_data_q) || (axis_in_tlast != hold_last_q));
`else
   logic unused_tdata;
   assign unused_tdata = ^axis_in_tdata;
   assign stable_err_c = 1'b0;
`endif

   // State and status registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         error_q <= '0;
         count_q <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         error_q <= error_d;
         count_q <= count_d;
         pkt_q   <= pkt_d;
      end
   end

   // Next state and newly detected errors
   always_comb begin
      state_d   = state_q;
      err_new_c = '0;
      unique case (state_q)
         S_IDLE: begin
            if (axis_in_tvalid) begin
               if (!axis_in_tready)    state_d = S_HEADER;
               else if (axis_in_tlast) err_new_c[E_TLAST] = 1'b1;
               else                    state_d = S_PAYLOAD;
            end
         end
         S_HEADER: begin
            if (!axis_in_tvalid)     err_new_c[E_DROPPED] = 1'b1;
            else if (beat_c) begin
               if (axis_in_tlast)    err_new_c[E_TLAST] = 1'b1;
               else                  state_d = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!axis_in_tvalid)     err_new_c[E_DROPPED] = 1'b1;
            else if (beat_c) begin
               if (axis_in_tlast) begin
                  if (len_ok_c)      state_d = S_IDLE;
                  else               err_new_c[E_SIZE] = 1'b1;
               end else if (count_q == CNT_MAX) begin
                  err_new_c[E_OVERFLOW] = 1'b1;
               end
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_q != S_FAULT && stable_err_c) err_new_c[E_UNSTABLE] = 1'b1;
      if (err_new_c != '0) state_d = S_FAULT;
      if (clear)           state_d = S_IDLE;
   end

   // Status outputs
   always_comb begin
      error_d = error_q | err_new_c;
      count_d = count_q;
      pkt_d   = pkt_q;
      unique case (state_q)
         S_IDLE, S_HEADER: begin
            if (beat_c && !axis_in_tlast) count_d = '0;
         end
         S_PAYLOAD: begin
            if (beat_c) begin
               if (axis_in_tlast) begin
                  count_d = CW'(len_c);
                  if (len_ok_c && (err_new_c == '0)) pkt_d = pkt_q + PCW'(1);
               end else if (count_q != CNT_MAX) begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         S_FAULT: begin
            error_d = error_q;
         end
         default: ;
      endcase
      if (clear) begin
         error_d = '0;
         count_d = '0;
         pkt_d   = pkt_q;
      end
   end

   assign error_code   = error_q;
   assign cycle_count  = count_q;
   assign packet_count = pkt_q;
   assign fault        = |error_q;

endmodule

// File: tb/tb_axis_xmit_monitor.sv
// Directed bench for axis_xmit_monitor: framing errors, clear, overflow (CW=4 instance),
// and the hold-stability check whose expectation follows XMIT_STABLE_CHECK_EN.
module tb_axis_xmit_monitor;

   localparam int unsigned DW = 512;

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] tdata;
   logic          tlast, tvalid, tready, clear;

   logic [4:0]    err, err4;
   logic [15:0]   cnt;
   logic [3:0]    cnt4;
   logic [31:0]   pkt, pkt4;
   logic          flt, flt4;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   axis_xmit_monitor dut (
      .clk(clk), .reset(reset), .axis_in_tdata(tdata), .axis_in_tlast(tlast),
      .axis_in_tvalid(tvalid), .axis_in_tready(tready), .clear(clear),
      .error_code(err), .cycle_count(cnt), .packet_count(pkt), .fault(flt));

   axis_xmit_monitor #(.CW(4)) dut4 (
      .clk(clk), .reset(reset), .axis_in_tdata(tdata), .axis_in_tlast(tlast),
      .axis_in_tvalid(tvalid), .axis_in_tready(tready), .clear(clear),
      .error_code(err4), .cycle_count(cnt4), .packet_count(pkt4), .fault(flt4));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of bus inputs, then sample just after the edge
   task automatic cyc(input logic v, input logic r, input logic l);
      tvalid = v;
      tready = r;
      tlast  = l;
      @(posedge clk);
      #1;
   endtask

   // Header plus n payload beats, tvalid held, tready randomly stalling
   task automatic send_pkt(input int n);
      logic r;
      for (int b = 0; b <= n; b++) begin
         tdata = {16{$urandom}};
         for (int t = 0; t < 8; t++) begin
            r = (t >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            cyc(1'b1, r, (b == n));
            if (r) break;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [4:0] exp_stable;
      logic [DW-1:0] d_a;
`ifdef XMIT_STABLE_CHECK_EN
      exp_stable = 5'b10000;
`else
      exp_stable = 5'b00000;
`endif
      reset = 1'b1; clear = 1'b0; tdata = '0;
      tvalid = 1'b0; tready = 1'b0; tlast = 1'b0;
      do_reset();
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_pkt", 64'(pkt), 64'd0);
      chk("rst_fault", 64'(flt), 64'd0);

      // Legal back-to-back traffic
      send_pkt(64);
      send_pkt(1);
      send_pkt(2);
      chk("legal_err", 64'(err), 64'd0);
      chk("legal_pkt", 64'(pkt), 64'd3);
      chk("legal_cnt", 64'(cnt), 64'd2);
      cyc(1'b0, 1'b0, 1'b0);
      chk("idle_err", 64'(err), 64'd0);

      // Header with tlast, then frozen counters
      cyc(1'b1, 1'b1, 1'b1);
      chk("hdr_tlast_err", 64'(err), 64'h01);
      chk("hdr_tlast_fault", 64'(flt), 64'd1);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("frozen_err", 64'(err), 64'h01);
      chk("frozen_cnt", 64'(cnt), 64'd2);
      chk("frozen_pkt", 64'(pkt), 64'd3);
      clear = 1'b1;
      cyc(1'b1, 1'b1, 1'b1);
      clear = 1'b0;
      chk("clr1_err", 64'(err), 64'd0);
      chk("clr1_cnt", 64'(cnt), 64'd0);
      chk("clr1_pkt", 64'(pkt), 64'd3);
      chk("clr1_fault", 64'(flt), 64'd0);

      // tvalid dropped after 10 payload beats
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("drop_pre_cnt", 64'(cnt), 64'd10);
      cyc(1'b0, 1'b0, 1'b0);
      chk("drop_err", 64'(err), 64'h02);
      chk("drop_cnt", 64'(cnt), 64'd10);
      clear = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clear = 1'b0;

      // Illegal size 3, then clear and a legal size-2 packet
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("size_err", 64'(err), 64'h04);
      chk("size_cnt", 64'(cnt), 64'd3);
      chk("size_pkt", 64'(pkt), 64'd3);
      clear = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);
      clear = 1'b0;
      chk("clr2_err", 64'(err), 64'd0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("after_clr_pkt", 64'(pkt), 64'd4);
      chk("after_clr_cnt", 64'(cnt), 64'd2);
      chk("after_clr_err", 64'(err), 64'd0);

      // Overflow on the CW=4 instance
      do_reset();
      cyc(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0);
      chk("ovf_pre_err", 64'(err4), 64'd0);
      chk("ovf_pre_cnt", 64'(cnt4), 64'd15);
      cyc(1'b1, 1'b1, 1'b0);
      chk("ovf_err", 64'(err4), 64'h08);
      chk("ovf_cnt", 64'(cnt4), 64'd15);
      chk("ovf_fault", 64'(flt4), 64'd1);
      chk("wide_cnt", 64'(cnt), 64'd16);
      chk("wide_err", 64'(err), 64'd0);

      // Data changed during a stall
      do_reset();
      tdata = {16{32'hA5A5_0001}};
      cyc(1'b1, 1'b0, 1'b0);
      tdata = {16{32'h5A5A_0002}};
      cyc(1'b1, 1'b0, 1'b0);
      chk("unstable_err", 64'(err), 64'(exp_stable));

      // Held data across a stall is legal
      do_reset();
      d_a = {16{32'h1234_5678}};
      tdata = d_a;
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      tdata = ~d_a;
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("stable_err", 64'(err), 64'd0);
      chk("stable_pkt", 64'(pkt), 64'd1);
      chk("stable_cnt", 64'(cnt), 64'd1);
      cyc(1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
